// File: rtl/impix_pio_pkg.sv
// Shared definitions for masters talking to the 4-bit switch PIO slave:
// register map and the servicer state encoding.
package impix_pio_pkg;

  localparam logic [1:0] PIO_REG_DATA = 2'd0;
  localparam logic [1:0] PIO_REG_MASK = 2'd2;
  localparam logic [1:0] PIO_REG_EDGE = 2'd3;

  typedef enum logic [3:0] {
    ST_INIT_MASK    = 4'd0,
    ST_IDLE         = 4'd1,
    ST_WR_MASK      = 4'd2,
    ST_RD_EDGE      = 4'd3,
    ST_RD_EDGE_WAIT = 4'd4,
    ST_CLR_EDGE     = 4'd5,
    ST_RD_DATA      = 4'd6,
    ST_RD_DATA_WAIT = 4'd7,
    ST_PUBLISH      = 4'd8,
    ST_HOLDOFF      = 4'd9
  } sw_srv_state_t;

endpackage

// File: rtl/impix_holdoff_counter.sv
// Loadable down-counter for debounce hold-off windows. After a load of N,
// done is high on the N-th cycle of counting (count == 1), so a caller that
// leaves its wait state on done spends exactly N cycles there.
module impix_holdoff_counter #(
  parameter int unsigned LOAD_VALUE = 50000,
  parameter int unsigned CNT_W      = $clog2(LOAD_VALUE + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VALUE);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= ZERO_CNT;
    end else if (load) begin
      cnt_r <= LOAD_CNT;
    end else if (dec && (cnt_r != ZERO_CNT)) begin
      cnt_r <= cnt_r - ONE_CNT;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == ONE_CNT);

endmodule

// File: rtl/impix_sw_irq_servicer.sv
// Avalon-MM master owning the switch PIO: programs the irq mask, services
// each interrupt (read + clear edge_capture, read levels), publishes a
// one-cycle event and then ignores the switches for a hold-off window.
module impix_sw_irq_servicer
  import impix_pio_pkg::*;
#(
  parameter int unsigned             WIDTH          = 4,
  parameter logic [WIDTH-1:0]        IRQ_MASK_INIT  = WIDTH'(4'hF),
  parameter int unsigned             HOLDOFF_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_wr,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_edges,
  output logic             sw_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [31-WIDTH:0] PAD_ZERO = {(32-WIDTH){1'b0}};

  sw_srv_state_t    state_r;
  sw_srv_state_t    next_state_s;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] mask_r;
  logic             mask_pend_r;
  logic             hold_done_s;

  logic             bus_cs_s;
  logic             bus_we_n_s;
  logic [1:0]       bus_addr_s;
  logic [31:0]      bus_wdata_s;
  logic             busy_s;
  logic             valid_s;

  // Only the switch bits of the read bus are meaningful.
  logic             rdata_unused_s;
  assign rdata_unused_s = ^m_readdata[31:WIDTH];

  impix_holdoff_counter #(
    .LOAD_VALUE (HOLDOFF_CYCLES),
    .CNT_W      (CNT_W)
  ) u_holdoff (
    .clk   (clk),
    .reset (reset),
    .load  (state_r == ST_PUBLISH),
    .dec   (state_r == ST_HOLDOFF),
    .done  (hold_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT_MASK;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a pending mask write outranks a new interrupt.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_INIT_MASK:    next_state_s = ST_IDLE;
      ST_IDLE: begin
        if (mask_pend_r) begin
          next_state_s = ST_WR_MASK;
        end else if (irq) begin
          next_state_s = ST_RD_EDGE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WR_MASK:      next_state_s = ST_IDLE;
      ST_RD_EDGE:      next_state_s = ST_RD_EDGE_WAIT;
      ST_RD_EDGE_WAIT: next_state_s = ST_CLR_EDGE;
      ST_CLR_EDGE:     next_state_s = ST_RD_DATA;
      ST_RD_DATA:      next_state_s = ST_RD_DATA_WAIT;
      ST_RD_DATA_WAIT: next_state_s = ST_PUBLISH;
      ST_PUBLISH:      next_state_s = ST_HOLDOFF;
      ST_HOLDOFF: begin
        if (hold_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLDOFF;
        end
      end
      default:         next_state_s = ST_INIT_MASK;
    endcase
  end

  // Output decode: bus cycle and flags for the state being entered, so the
  // registered outputs line up with the state. The init write is issued as
  // INIT_MASK is left, since reset itself must hold the bus idle.
  always_comb begin
    bus_cs_s    = 1'b0;
    bus_we_n_s  = 1'b1;
    bus_addr_s  = PIO_REG_DATA;
    bus_wdata_s = 32'd0;
    if (state_r == ST_INIT_MASK) begin
      bus_cs_s    = 1'b1;
      bus_we_n_s  = 1'b0;
      bus_addr_s  = PIO_REG_MASK;
      bus_wdata_s = {PAD_ZERO, IRQ_MASK_INIT};
    end else begin
      case (next_state_s)
        ST_WR_MASK: begin
          bus_cs_s    = 1'b1;
          bus_we_n_s  = 1'b0;
          bus_addr_s  = PIO_REG_MASK;
          bus_wdata_s = {PAD_ZERO, mask_r};
        end
        ST_RD_EDGE: begin
          bus_cs_s    = 1'b1;
          bus_addr_s  = PIO_REG_EDGE;
        end
        ST_CLR_EDGE: begin
          // Read data arrives this cycle; it is the value being latched.
          bus_cs_s    = 1'b1;
          bus_we_n_s  = 1'b0;
          bus_addr_s  = PIO_REG_EDGE;
          bus_wdata_s = {PAD_ZERO, m_readdata[WIDTH-1:0]};
        end
        ST_RD_DATA: begin
          bus_cs_s    = 1'b1;
          bus_addr_s  = PIO_REG_DATA;
        end
        default: begin
          bus_cs_s    = 1'b0;
        end
      endcase
    end
    busy_s  = (next_state_s != ST_IDLE) || (state_r == ST_INIT_MASK);
    valid_s = (next_state_s == ST_PUBLISH);
  end

  // Registered bus and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= PIO_REG_DATA;
      m_writedata  <= 32'd0;
      sw_valid     <= 1'b0;
      busy         <= 1'b1;
    end else begin
      m_chipselect <= bus_cs_s;
      m_write_n    <= bus_we_n_s;
      m_address    <= bus_addr_s;
      m_writedata  <= bus_wdata_s;
      sw_valid     <= valid_s;
      busy         <= busy_s;
    end
  end

  // Edge latch from the edge_capture read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_RD_EDGE_WAIT) begin
      edge_r <= m_readdata[WIDTH-1:0];
    end else begin
      edge_r <= edge_r;
    end
  end

  // Published event: the level read lands straight in sw_state, so it and
  // sw_edges change together with the sw_valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_state <= {WIDTH{1'b0}};
      sw_edges <= {WIDTH{1'b0}};
    end else if (state_r == ST_RD_DATA_WAIT) begin
      sw_state <= m_readdata[WIDTH-1:0];
      sw_edges <= edge_r;
    end else begin
      sw_state <= sw_state;
      sw_edges <= sw_edges;
    end
  end

  // Mask request latch; the flag drops when IDLE commits to the write, and a
  // request in that same cycle re-arms it so the newer value is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r      <= {WIDTH{1'b0}};
      mask_pend_r <= 1'b0;
    end else if (cfg_mask_wr) begin
      mask_r      <= cfg_mask;
      mask_pend_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && mask_pend_r) begin
      mask_r      <= mask_r;
      mask_pend_r <= 1'b0;
    end else begin
      mask_r      <= mask_r;
      mask_pend_r <= mask_pend_r;
    end
  end

endmodule

// File: tb/tb_impix_sw_irq_servicer.sv
// Bench for impix_sw_irq_servicer: a behavioural PIO slave, a timeline model
// of the expected bus/event activity checked every cycle, directed scenarios
// with literal expectations, and a randomized phase.
module tb_impix_sw_irq_servicer;

  localparam int W = 4;
  localparam int H = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq_force = 1'b0;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic [3:0]  cfg_mask = 4'd0;
  logic        cfg_mask_wr = 1'b0;
  logic [3:0]  sw_state;
  logic [3:0]  sw_edges;
  logic        sw_valid;
  logic        busy;

  // PIO slave model state
  logic [3:0]  sw_in = 4'd0;
  logic [3:0]  sw_prev = 4'd0;
  logic [3:0]  pio_edge = 4'd0;
  logic [3:0]  pio_mask = 4'd0;
  logic [31:0] pio_rdata = 32'd0;
  logic        pio_irq;
  logic        irq_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  impix_sw_irq_servicer #(
    .WIDTH          (W),
    .IRQ_MASK_INIT  (4'hF),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq_s),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .cfg_mask     (cfg_mask),
    .cfg_mask_wr  (cfg_mask_wr),
    .sw_state     (sw_state),
    .sw_edges     (sw_edges),
    .sw_valid     (sw_valid),
    .busy         (busy)
  );

  // PIO: any-edge capture, clear-all on write to reg 3, registered read data.
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n && (m_address == 2'd2)) pio_mask <= m_writedata[3:0];
    if (m_chipselect && m_write_n) begin
      case (m_address)
        2'd0:    pio_rdata <= {28'd0, sw_in};
        2'd2:    pio_rdata <= {28'd0, pio_mask};
        2'd3:    pio_rdata <= {28'd0, pio_edge};
        default: pio_rdata <= 32'd0;
      endcase
    end
    pio_edge <= (((m_chipselect && !m_write_n && (m_address == 2'd3)) ? 4'd0 : pio_edge)
                 | (sw_in ^ sw_prev));
    sw_prev <= sw_in;
  end

  assign pio_irq    = |(pio_edge & pio_mask);
  assign irq_s      = pio_irq | irq_force;
  assign m_readdata = pio_rdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- timeline model ----------------
  // After a decision in an idle cycle t0 the service occupies t0+1..t0+6+H:
  // read edge at +1, clear at +3, read levels at +4, event at +6.
  int          cyc = 0;
  int          rel_cnt = -1;
  int          free_at = 0;
  int          t0 = 0;
  int          op_kind = 0;
  int          d;
  logic [3:0]  op_mask = 4'd0;
  logic [3:0]  cap_edges = 4'd0;
  logic [3:0]  cap_level = 4'd0;
  logic [3:0]  exp_state = 4'd0;
  logic [3:0]  exp_edges = 4'd0;
  logic [3:0]  pend_val = 4'd0;
  logic        pend_m = 1'b0;
  logic        e_cs, e_wen, e_valid, e_busy;
  logic [1:0]  e_addr;
  logic [31:0] e_wd;

  always @(negedge clk) begin
    cyc = cyc + 1;
    e_cs = 1'b0; e_wen = 1'b1; e_addr = 2'd0; e_wd = 32'd0; e_valid = 1'b0; e_busy = 1'b0;
    if (reset) begin
      rel_cnt = -1; op_kind = 0; pend_m = 1'b0;
      exp_state = 4'd0; exp_edges = 4'd0; e_busy = 1'b1;
    end else begin
      rel_cnt = rel_cnt + 1;
      if (rel_cnt == 0) begin
        e_busy = 1'b1;
      end else if (rel_cnt == 1) begin
        e_cs = 1'b1; e_wen = 1'b0; e_addr = 2'd2; e_wd = 32'h0000000F; e_busy = 1'b1;
        free_at = cyc;
      end
      if ((op_kind != 0) && (cyc < free_at)) begin
        d = cyc - t0;
        e_busy = 1'b1;
        if (op_kind == 1) begin
          e_cs = 1'b1; e_wen = 1'b0; e_addr = 2'd2; e_wd = {28'd0, op_mask};
        end else begin
          case (d)
            1: begin e_cs = 1'b1; e_addr = 2'd3; cap_edges = pio_edge; end
            3: begin e_cs = 1'b1; e_wen = 1'b0; e_addr = 2'd3; e_wd = {28'd0, cap_edges}; end
            4: begin e_cs = 1'b1; e_addr = 2'd0; cap_level = sw_in; end
            6: begin e_valid = 1'b1; exp_state = cap_level; exp_edges = cap_edges; end
            default: ;
          endcase
        end
      end
      if ((rel_cnt >= 1) && (cyc >= free_at)) begin
        if (pend_m) begin
          op_kind = 1; op_mask = pend_val; pend_m = 1'b0; t0 = cyc; free_at = cyc + 2;
        end else if (irq_s) begin
          op_kind = 2; t0 = cyc; free_at = cyc + 7 + H;
        end else begin
          op_kind = 0;
        end
      end
      if (cfg_mask_wr) begin
        pend_m = 1'b1; pend_val = cfg_mask;
      end
    end
    check($sformatf("chipselect@%0d", cyc), {31'd0, m_chipselect}, {31'd0, e_cs});
    check($sformatf("write_n@%0d", cyc), {31'd0, m_write_n}, {31'd0, e_wen});
    check($sformatf("sw_valid@%0d", cyc), {31'd0, sw_valid}, {31'd0, e_valid});
    check($sformatf("busy@%0d", cyc), {31'd0, busy}, {31'd0, e_busy});
    check($sformatf("sw_state@%0d", cyc), {28'd0, sw_state}, {28'd0, exp_state});
    check($sformatf("sw_edges@%0d", cyc), {28'd0, sw_edges}, {28'd0, exp_edges});
    if (e_cs) begin
      check($sformatf("address@%0d", cyc), {30'd0, m_address}, {30'd0, e_addr});
      check($sformatf("writedata@%0d", cyc), m_writedata, e_wd);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_valid(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (sw_valid) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic wait_cs(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (m_chipselect) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget && quiet < 3; i++) begin
      tick();
      if (!busy && !pio_irq) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) timeout_fail(name);
  endtask

  initial begin
    int n;
    int cs_cnt;
    bit done;

    // reset values
    repeat (3) tick();
    check("rst cs", {31'd0, m_chipselect}, 32'd0);
    check("rst write_n", {31'd0, m_write_n}, 32'd1);
    check("rst address", {30'd0, m_address}, 32'd0);
    check("rst writedata", m_writedata, 32'd0);
    check("rst valid", {31'd0, sw_valid}, 32'd0);
    check("rst state", {28'd0, sw_state}, 32'd0);
    check("rst edges", {28'd0, sw_edges}, 32'd0);
    reset = 1'b0;

    // init mask write on the first cycle, busy drops next
    tick();
    check("init cs", {31'd0, m_chipselect}, 32'd1);
    check("init write_n", {31'd0, m_write_n}, 32'd0);
    check("init address", {30'd0, m_address}, 32'd2);
    check("init data", m_writedata, 32'h0000000F);
    check("init busy", {31'd0, busy}, 32'd1);
    tick();
    check("post-init cs", {31'd0, m_chipselect}, 32'd0);
    check("post-init busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();

    // single switch edge: latency and payload
    sw_in = 4'b0100;
    tick();
    check("irq raised", {31'd0, pio_irq}, 32'd1);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      n++;
      if (n == 4) check("irq cleared", {31'd0, pio_irq}, 32'd0);
      if (sw_valid) done = 1'b1;
    end
    if (!done) timeout_fail("first event");
    check("event latency", n, 32'd6);
    check("event edges", {28'd0, sw_edges}, 32'h4);
    check("event state", {28'd0, sw_state}, 32'h4);

    // chatter on bit0 plus a mask request during hold-off
    cs_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < 100; j++) begin
        tick();
        if (m_chipselect) cs_cnt++;
      end
      sw_in[0] = ~sw_in[0];
      if (k == 2) begin
        cfg_mask = 4'b0011;
        cfg_mask_wr = 1'b1;
        tick();
        if (m_chipselect) cs_cnt++;
        cfg_mask_wr = 1'b0;
      end
    end
    check("holdoff bus quiet", cs_cnt, 32'd0);
    wait_cs(300, "mask write after holdoff");
    check("mask wr write_n", {31'd0, m_write_n}, 32'd0);
    check("mask wr address", {30'd0, m_address}, 32'd2);
    check("mask wr data", m_writedata, 32'h00000003);
    wait_cs(10, "edge read after mask");
    check("edge read address", {30'd0, m_address}, 32'd3);
    wait_valid(30, "chatter event");
    check("chatter edges", {28'd0, sw_edges}, 32'h1);
    check("chatter state", {28'd0, sw_state}, 32'h5);
    wait_idle(3000, "idle after chatter");

    // spurious irq with empty edge_capture
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    wait_valid(20, "spurious event");
    check("spurious edges", {28'd0, sw_edges}, 32'h0);
    check("spurious state", {28'd0, sw_state}, 32'h5);
    wait_idle(3000, "idle after spurious");

    // randomized traffic
    for (int i = 0; i < 12000; i++) begin
      tick();
      irq_force = ($urandom_range(0, 499) == 0);
      cfg_mask_wr = ($urandom_range(0, 299) == 0);
      cfg_mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 39) == 0) sw_in[$urandom_range(0, 3)] = ~sw_in[$urandom_range(0, 3)];
    end
    tick();
    irq_force = 1'b0;
    cfg_mask = 4'hF;
    cfg_mask_wr = 1'b1;
    tick();
    cfg_mask_wr = 1'b0;
    wait_idle(6000, "idle after random");

    // reset in the middle of the clear write
    sw_in[3] = ~sw_in[3];
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (m_chipselect && !m_write_n && (m_address == 2'd3)) done = 1'b1;
    end
    if (!done) timeout_fail("clear write");
    reset = 1'b1;
    #1;
    check("abort cs", {31'd0, m_chipselect}, 32'd0);
    check("abort write_n", {31'd0, m_write_n}, 32'd1);
    check("abort writedata", m_writedata, 32'd0);
    check("abort state", {28'd0, sw_state}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("reinit address", {30'd0, m_address}, 32'd2);
    check("reinit data", m_writedata, 32'h0000000F);
    wait_valid(30, "stale irq event");
    check("stale edges", {28'd0, sw_edges}, 32'h8);
    check("stale state", {28'd0, sw_state}, {28'd0, sw_in});
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/impix_sw_irq_servicer.md
Name: impix_sw_irq_servicer

Overview:
- Avalon-MM master that owns the 4-bit switch PIO slave (regs: 0 = data, 2 = irq_mask, 3 = edge_capture).
- After reset it programs the irq mask. On each irq it reads and clears edge_capture, then samples the switch levels.
- Publishes a single-cycle event (levels + changed bits) to the pixelization datapath, then enforces a hold-off window that debounces switch chatter.

Parameters:
- WIDTH, 4, switch count; matches the PIO in_port width.
- IRQ_MASK_INIT, 4'hF, mask value written to PIO reg 2 after reset.
- HOLDOFF_CYCLES, 50000, cycles ignored after each publish (1 ms at 50 MHz); must be >= 1.
- CNT_W, $clog2(HOLDOFF_CYCLES+1), hold-off counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- irq  in  1  PIO interrupt, level.
- m_address  out  2  PIO register address.
- m_chipselect  out  1  PIO select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  write data; upper bits are 0.
- m_readdata  in  32  PIO read data; registered in the slave, so valid 1 cycle after the address is driven.
- cfg_mask  in  WIDTH  new irq mask.
- cfg_mask_wr  in  1  one-cycle request to write cfg_mask.
- sw_state  out  WIDTH  last sampled switch levels.
- sw_edges  out  WIDTH  edge bits captured for the last event.
- sw_valid  out  1  one-cycle pulse; sw_state and sw_edges are updated in the same cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = INIT_MASK, m_chipselect = 0, m_write_n = 1, m_address = 0, m_writedata = 0.
  - sw_state = 0, sw_edges = 0, sw_valid = 0, hold-off counter = 0, pending-mask flag = 0.
  - Reset asserted mid-transaction aborts it immediately. The PIO may keep a stale edge_capture, but irq stays asserted, so it is serviced after re-init.
- All outputs are registered. The bus is driven for exactly one cycle per access.
- Reads drive m_chipselect = 1, m_write_n = 1. Writes drive m_chipselect = 1, m_write_n = 0.
- States and transitions:
  - INIT_MASK: write IRQ_MASK_INIT to address 2; -> IDLE.
  - IDLE: if the pending-mask flag is set -> WR_MASK; else if irq = 1 -> RD_EDGE; else stay.
  - WR_MASK: write the latched cfg_mask to address 2; clear the flag; -> IDLE.
  - RD_EDGE: drive address 3 (read); -> RD_EDGE_WAIT.
  - RD_EDGE_WAIT: bus idle; latch m_readdata[WIDTH-1:0] into the edge register; -> CLR_EDGE.
  - CLR_EDGE: write address 3 with data = the latched edges. The PIO clears all bits on any write to reg 3. -> RD_DATA.
  - RD_DATA: drive address 0 (read); -> RD_DATA_WAIT.
  - RD_DATA_WAIT: latch m_readdata[WIDTH-1:0] into the level register; -> PUBLISH.
  - PUBLISH: sw_valid = 1 this cycle; sw_state and sw_edges take the latched values; load counter = HOLDOFF_CYCLES; -> HOLDOFF.
  - HOLDOFF: decrement the counter each cycle; irq is ignored. When the counter reaches 1 -> IDLE, giving exactly HOLDOFF_CYCLES cycles in HOLDOFF.
- Latency: irq high in IDLE at cycle N gives sw_valid at cycle N+6. The bus sequence is RD_EDGE at N+1, CLR at N+3, RD_DATA at N+4.
- Events that are lost by design:
  - Edges arriving between the RD_EDGE sample and CLR_EDGE are cleared unseen. The levels read in RD_DATA still reflect them in sw_state.
  - Edges that stay latched in the PIO during HOLDOFF keep irq high and are serviced on return to IDLE.
- Latched edges = 0 (spurious irq or mask race): still publish, with sw_edges = 0.
- cfg_mask_wr in any state latches cfg_mask and sets the pending flag.
  - A later request before service overwrites the latched value (last wins).
  - In IDLE, a pending mask write takes priority over irq.
  - cfg_mask_wr and irq arriving in the same IDLE cycle: the flag is not yet visible, so irq is serviced first and the mask write follows on the next IDLE.
- m_writedata for mask and clear writes = {(32-WIDTH){0}, value}.

Decomposition:
- Shared package impix_pio_pkg:
  - register address constants PIO_REG_DATA = 2'd0, PIO_REG_MASK = 2'd2, PIO_REG_EDGE = 2'd3.
  - state enum typedef sw_srv_state_t.
- One natural sub-module: impix_holdoff_counter (load, count-down, done flag), reusable for other debounce paths.
- The FSM and bus driver stay in the top module.

Test Plan:
- Release reset -> one write at address 2 with data 0x0000000F on the first cycle; busy drops the next cycle; then bus idle.
- Bench PIO model: in_port 0000 -> 0100 (edge_capture = 4'b0100, irq = 1) -> bus order read 3, write 3, read 0; sw_valid at irq+6 with sw_edges = 4'b0100, sw_state = 4'b0100; PIO irq drops after the clear.
- Toggle in_port bit0 every 100 cycles during HOLDOFF (HOLDOFF_CYCLES = 1000) -> no bus activity until the hold-off ends; then exactly one service with sw_edges bit0 = 1 and sw_state = the current level.
- cfg_mask_wr = 1 with cfg_mask = 4'b0011 during a service -> write address 2, data 0x3, immediately after HOLDOFF and ahead of a still-pending irq.
- Force irq = 1 while edge_capture = 0 -> sw_valid with sw_edges = 0000 and sw_state = the current levels.
- Assert reset during CLR_EDGE -> outputs return to reset values that same cycle; after release, INIT_MASK rewrites 0xF, then the still-high irq is serviced.
